// File: rtl/cpu_uart_pkg.sv
// cpu_uart_pkg
//   Definitions shared by the CPU UART receiver and transmitter: FSM state
//   encoding, default oversampling ratio and word size, and 8N1 line levels.
package cpu_uart_pkg;

  // Default timebase: baud_rate_clock ticks per bit, and data bits per frame.
  localparam int unsigned UART_OVS       = 64;
  localparam int unsigned UART_DATA_BITS = 8;

  // 8N1 line levels.
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/cpu_uart_tick_sync.sv
// cpu_uart_tick_sync
//   Brings the baud generator's oversample clock into the system_clk domain
//   as ordinary data and turns each synchronised rising edge into a
//   one-cycle tick. Shared by the RX and TX sides.
// Ports
//   system_clk  in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   async_in    in   oversample clock from the baud generator
//   tick        out  1-cycle pulse per synchronised rising edge of async_in
module cpu_uart_tick_sync (
  input  logic system_clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic [1:0] sync_q;
  logic       prev_q;

  // All flops reset high so that leaving reset never produces a false edge.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign tick = sync_q[1] & ~prev_q;

endmodule

// File: rtl/cpu_uart_rx.sv
// cpu_uart_rx
//   8N1 UART receiver timed by the oversample ticks of the CPU baud-rate
//   generator. Delivers bytes through an rx_valid/rx_ack handshake and flags
//   framing errors (pulse) and overruns (sticky until acknowledged).
// Ports
//   system_clk       in   system clock, rising edge
//   reset            in   asynchronous, active-low reset
//   baud_rate_clock  in   oversample clock (OVS ticks per bit), treated as data
//   uart_rx          in   serial line, idle high, asynchronous
//   rx_ack           in   1-cycle pulse: consumer has taken rx_data
//   rx_data          out  last good byte, held until overwritten
//   rx_valid         out  byte available, high until rx_ack
//   rx_frame_err     out  1-cycle pulse: stop bit sampled low
//   rx_overrun       out  sticky: byte completed while previous one unread
//   rx_busy          out  receiver not idle
module cpu_uart_rx
  import cpu_uart_pkg::*;
#(
  parameter int unsigned OVS       = UART_OVS,
  parameter int unsigned DATA_BITS = UART_DATA_BITS
) (
  input  logic                 system_clk,
  input  logic                 reset,
  input  logic                 baud_rate_clock,
  input  logic                 uart_rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(OVS);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 tick;
  logic [1:0]           rx_sync;
  logic                 rxs;
  uart_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bitn;
  logic [DATA_BITS-1:0] shift;
  logic                 ack_take;

  cpu_uart_tick_sync u_tick_sync (
    .system_clk (system_clk),
    .reset      (reset),
    .async_in   (baud_rate_clock),
    .tick       (tick)
  );

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      rx_sync <= {2{UART_IDLE_LEVEL}};
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
    end
  end

  assign rxs      = rx_sync[1];
  assign ack_take = rx_ack & rx_valid;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bitn         <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;

      // Handshake first; a frame load below overrides rx_valid in the same
      // cycle so a simultaneous ack and load keeps the new byte valid.
      if (ack_take) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (rxs == UART_START_LEVEL) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (cnt == CNT_HALF) begin
              if (rxs != UART_START_LEVEL) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= DATA;
                cnt   <= '0;
                bitn  <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (cnt == CNT_FULL) begin
              shift[bitn] <= rxs;
              cnt         <= '0;
              if (bitn == BIT_LAST) begin
                state <= STOP;
              end else begin
                bitn <= bitn + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (cnt == CNT_FULL) begin
              if (rxs == UART_STOP_LEVEL) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) begin
                  rx_overrun <= 1'b1;
                end
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        BREAK: begin
          // Only a return to idle level re-arms start detection.
          if (rxs == UART_IDLE_LEVEL) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
